// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing helpers for sync_fifo (depth, count width, almost-full offset)
package sync_fifo_pkg;

   localparam int AFULL_OFFSET = 2;

   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction

   function automatic int count_width(input int aw);
      return aw + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - synchronous dual-port RAM, registered read, returns old data on read-during-write
module sync_fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [XLEN-1:0]       i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [XLEN-1:0]       o_q
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   logic [XLEN-1:0] r_mem [DEPTH];
   logic [XLEN-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_q <= r_mem[i_raddr];
   end

   assign o_q = r_q;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO over sync_fifo_ram; SYNC_FIFO_ERR_EN adds sticky o_err
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int ADDR_WIDTH   = 4,
   parameter int AFULL_THRESH = fifo_depth(ADDR_WIDTH) - AFULL_OFFSET
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wr_valid,
   output logic                  o_wr_ready,
   input  logic [XLEN-1:0]       i_wr_data,
   output logic                  o_rd_valid,
   input  logic                  i_rd_ready,
   output logic [XLEN-1:0]       o_rd_data,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_afull
`ifdef SYNC_FIFO_ERR_EN
   ,
   output logic                  o_err
`endif
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);
   localparam int CW    = count_width(ADDR_WIDTH);

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [CW-1:0]         r_rd_count;
   logic                  r_pop_prev;
   logic                  r_afull;

   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;
   logic [CW-1:0]         w_vis_count;
   logic [CW-1:0]         w_count_next;
   logic [ADDR_WIDTH-1:0] w_raddr;

   assign w_full     = (r_count == CW'(DEPTH));
   assign o_wr_ready = !i_rst && !w_full;

   // The RAM returns old data on a same-address read/write, so a word pushed
   // last cycle is not yet readable: visibility lags the committed count by one.
   assign w_vis_count = r_rd_count - CW'(r_pop_prev);
   assign o_rd_valid  = !i_rst && (w_vis_count != '0);

   assign w_push       = i_wr_valid && o_wr_ready;
   assign w_pop        = o_rd_valid && i_rd_ready;
   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
   assign w_raddr      = r_rd_ptr + ADDR_WIDTH'(w_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_count <= '0;
         r_pop_prev <= 1'b0;
         r_afull    <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count    <= w_count_next;
         r_rd_count <= r_count;
         r_pop_prev <= w_pop;
         r_afull    <= (w_count_next >= CW'(AFULL_THRESH));
      end
   end

   assign o_count = r_count;
   assign o_afull = r_afull;

`ifdef SYNC_FIFO_ERR_EN
   logic r_err;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_err <= 1'b0;
      end else if (i_wr_valid && w_full) begin
         r_err <= 1'b1;
      end
   end

   assign o_err = r_err;
`endif

   sync_fifo_ram #(
      .XLEN       (XLEN),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (i_wr_data),
      .i_raddr (w_raddr),
      .o_q     (o_rd_data)
   );

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo against a queue-based reference model
module tb_sync_fifo;

   localparam int DEPTH  = 16;
   localparam int THRESH = 14;

   typedef struct {
      logic [31:0] d;
      int          c;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wv  = 1'b0;
   logic [31:0] wd  = '0;
   logic        rr  = 1'b0;
   logic        o_wr_ready;
   logic        o_rd_valid;
   logic [31:0] o_rd_data;
   logic [4:0]  o_count;
   logic        o_afull;
`ifdef SYNC_FIFO_ERR_EN
   logic        o_err;
   logic        m_err = 1'b0;
`endif

   int     n_chk = 0;
   int     n_err = 0;
   int     cyc   = 0;
   entry_t m_q[$];

   sync_fifo dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wr_valid (wv),
      .o_wr_ready (o_wr_ready),
      .i_wr_data  (wd),
      .o_rd_valid (o_rd_valid),
      .i_rd_ready (rr),
      .o_rd_data  (o_rd_data),
      .o_count    (o_count),
      .o_afull    (o_afull)
`ifdef SYNC_FIFO_ERR_EN
      ,
      .o_err      (o_err)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   // Reference model: a word is readable once two cycles have passed since its push.
   always @(negedge clk) begin
      if (cyc > 0) begin
         bit vis;
         bit m_push;
         bit m_pop;
         vis = (m_q.size() > 0) && (m_q[0].c <= cyc - 2);
         chk("mon_rd_valid", o_rd_valid, !rst && vis);
         chk("mon_wr_ready", o_wr_ready, !rst && (m_q.size() != DEPTH));
         chk("mon_count", o_count, m_q.size());
         chk("mon_afull", o_afull, m_q.size() >= THRESH);
`ifdef SYNC_FIFO_ERR_EN
         chk("mon_err", o_err, m_err);
         if (rst) m_err = 1'b0;
         else if (wv && m_q.size() == DEPTH) m_err = 1'b1;
`endif
         m_pop  = !rst && rr && vis;
         m_push = !rst && wv && (m_q.size() != DEPTH);
         if (m_pop) begin
            chk("mon_rd_data", o_rd_data, m_q[0].d);
            void'(m_q.pop_front());
         end
         if (m_push) m_q.push_back('{d: wd, c: cyc});
         if (rst) m_q.delete();
      end
   end

   task automatic set_in(input logic v, input logic [31:0] d, input logic r, input logic rs);
      wv  = v;
      wd  = d;
      rr  = r;
      rst = rs;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 32'hAAAA_0000, 1'b1, 1'b1);
         #1;
         chk("rst_wr_ready", o_wr_ready, 1'b0);
         chk("rst_rd_valid", o_rd_valid, 1'b0);
         tick();
      end
      set_in(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("rel_wr_ready", o_wr_ready, 1'b1);
      chk("rel_count", o_count, 5'd0);
      tick();

      set_in(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("single_k1_valid", o_rd_valid, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("single_valid", o_rd_valid, 1'b1);
         chk("single_data", o_rd_data, 32'hDEADBEEF);
         tick();
      end
      set_in(1'b0, '0, 1'b1, 1'b0);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("single_pop_valid", o_rd_valid, 1'b0);
      chk("single_pop_count", o_count, 5'd0);
      tick();

      for (int i = 0; i < 17; i++) begin
         set_in(1'b1, 32'(i), 1'b0, 1'b0);
         tick();
      end
      set_in(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("full_count", o_count, 5'd16);
      chk("full_wr_ready", o_wr_ready, 1'b0);
      chk("full_afull", o_afull, 1'b1);
`ifdef SYNC_FIFO_ERR_EN
      chk("full_err", o_err, 1'b1);
`endif
      for (int i = 0; i < 18; i++) begin
         set_in(1'b0, '0, 1'b1, 1'b0);
         tick();
      end

      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
         tick();
      end
      set_in(1'b0, '0, 1'b0, 1'b0);
      tick();
      tick();
      for (int i = 0; i < 100; i++) begin
         set_in(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
         #1;
         chk("stream_valid", o_rd_valid, 1'b1);
         chk("stream_count", o_count, 5'd2);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         set_in(1'b0, '0, 1'b1, 1'b0);
         tick();
      end

      set_in(1'b1, 32'hA1A1_A1A1, 1'b0, 1'b0);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 32'hB2B2_B2B2, 1'b1, 1'b0);
      #1;
      chk("c1_old_data", o_rd_data, 32'hA1A1_A1A1);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("c1_count", o_count, 5'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, '0, 1'b1, 1'b0);
         tick();
      end

      for (int i = 0; i < 9; i++) begin
         set_in(1'b1, 32'h900 + 32'(i), 1'b0, 1'b0);
         tick();
      end
      set_in(1'b0, '0, 1'b0, 1'b0);
      tick();
      #1;
      chk("mid_count9", o_count, 5'd9);
      set_in(1'b0, '0, 1'b0, 1'b1);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("mid_rst_count", o_count, 5'd0);
      chk("mid_rst_valid", o_rd_valid, 1'b0);
      set_in(1'b1, 32'h1234, 1'b0, 1'b0);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0);
      tick();
      set_in(1'b0, '0, 1'b1, 1'b0);
      #1;
      chk("mid_new_valid", o_rd_valid, 1'b1);
      chk("mid_new_data", o_rd_data, 32'h1234);
      tick();

      for (int seg = 0; seg < 6; seg++) begin
         int wbias;
         int rbias;
         wbias = (seg % 3 == 0) ? 80 : (seg % 3 == 1) ? 50 : 25;
         rbias = (seg % 2 == 0) ? 40 : 85;
         for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(99) < wbias, $urandom, $urandom_range(99) < rbias,
                   $urandom_range(299) == 0);
            tick();
         end
      end
      for (int i = 0; i < 24; i++) begin
         set_in(1'b0, '0, 1'b1, 1'b0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
